// File: rtl/ntsc_pkg.sv
// Shared constants for the NTSC composite scan-out path.
// DAC levels and fetch-FSM state encoding.
package ntsc_pkg;

    localparam logic [1:0] LVL_SYNC  = 2'b00;
    localparam logic [1:0] LVL_BLACK = 2'b01;
    localparam logic [1:0] LVL_WHITE = 2'b11;

    typedef enum logic [1:0] {
        FIDLE  = 2'd0,
        FADDR  = 2'd1,
        FWAIT  = 2'd2,
        FLATCH = 2'd3
    } fstate_t;

endpackage

// File: rtl/ntsc_timing.sv
// Raster counters and decoded timing flags for the composite scan-out.
// The pixel index is tracked incrementally so no divider is needed.
module ntsc_timing #(
    parameter int LINE_CLKS   = 3178,
    parameter int HSYNC_CLKS  = 235,
    parameter int BP_CLKS     = 235,
    parameter int H_OFFSET    = 220,
    parameter int PIX_CLKS    = 36,
    parameter int LINES       = 262,
    parameter int VSYNC_LINES = 3,
    parameter int V_START     = 40,
    parameter int ROW_LINES   = 6
) (
    input  logic       clock,
    input  logic       aclr_n,
    output logic [5:0] pix,
    output logic       in_sync,
    output logic       in_active,
    output logic       disp_line,
    output logic       fetch_start,
    output logic       line_end,
    output logic       row_clr,
    output logic       frame_tick
);
    import ntsc_pkg::*;

    localparam int A     = HSYNC_CLKS + BP_CLKS + H_OFFSET;
    localparam int A_END = A + 64 * PIX_CLKS;
    localparam int V_END = V_START + 32 * ROW_LINES;
    localparam int HW    = $clog2(LINE_CLKS + 1);
    localparam int VW    = $clog2(LINES + 1);
    localparam int PW    = $clog2(PIX_CLKS + 1);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [PW-1:0] psub;
    logic          vsync;

    assign line_end  = (hcnt == HW'(LINE_CLKS - 1));
    assign vsync     = (vcnt < VW'(VSYNC_LINES));
    assign in_sync   = vsync ? (hcnt < HW'(LINE_CLKS - HSYNC_CLKS))
                             : (hcnt < HW'(HSYNC_CLKS));
    assign in_active = (hcnt >= HW'(A)) && (hcnt < HW'(A_END));
    assign disp_line = (vcnt >= VW'(V_START)) && (vcnt < VW'(V_END));
    assign fetch_start = disp_line && (hcnt == HW'(HSYNC_CLKS));
    assign row_clr   = line_end && (vcnt == VW'(V_START - 1));

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            hcnt       <= '0;
            vcnt       <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= line_end && (vcnt == VW'(LINES - 1));
            if (line_end) begin
                hcnt <= '0;
                if (vcnt == VW'(LINES - 1)) vcnt <= '0;
                else vcnt <= vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // Realigned one clock before the window so pix is 0 on its first clock
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            pix  <= '0;
            psub <= '0;
        end else if (hcnt == HW'(A - 1)) begin
            pix  <= '0;
            psub <= '0;
        end else if (psub == PW'(PIX_CLKS - 1)) begin
            pix  <= pix + 1'b1;
            psub <= '0;
        end else begin
            psub <= psub + 1'b1;
        end
    end

endmodule

// File: rtl/ntsc_scanout.sv
// CHIP-8 frame buffer to two-pin composite DAC scan-out.
// Fetches one VRAM row per scan line and shifts it out as pixels.
module ntsc_scanout #(
    parameter int LINE_CLKS   = 3178,
    parameter int HSYNC_CLKS  = 235,
    parameter int BP_CLKS     = 235,
    parameter int H_OFFSET    = 220,
    parameter int PIX_CLKS    = 36,
    parameter int LINES       = 262,
    parameter int VSYNC_LINES = 3,
    parameter int V_START     = 40,
    parameter int ROW_LINES   = 6
) (
    input  logic        clock,
    input  logic        aclr_n,
    output logic [4:0]  address_a,
    input  logic [63:0] q_a,
    output logic        clock_a,
    output logic        high,
    output logic        low,
    output logic        frame_tick
);
    import ntsc_pkg::*;

    localparam int SW = $clog2(ROW_LINES + 1);

    logic [5:0]    pix;
    logic          in_sync;
    logic          in_active;
    logic          disp_line;
    logic          fetch_start;
    logic          line_end;
    logic          row_clr;
    logic [4:0]    row;
    logic [SW-1:0] sub;
    logic [63:0]   linebuf;
    fstate_t       state;
    logic [1:0]    lvl;

    assign clock_a = clock;

    ntsc_timing #(
        .LINE_CLKS   (LINE_CLKS),
        .HSYNC_CLKS  (HSYNC_CLKS),
        .BP_CLKS     (BP_CLKS),
        .H_OFFSET    (H_OFFSET),
        .PIX_CLKS    (PIX_CLKS),
        .LINES       (LINES),
        .VSYNC_LINES (VSYNC_LINES),
        .V_START     (V_START),
        .ROW_LINES   (ROW_LINES)
    ) u_timing (
        .clock       (clock),
        .aclr_n      (aclr_n),
        .pix         (pix),
        .in_sync     (in_sync),
        .in_active   (in_active),
        .disp_line   (disp_line),
        .fetch_start (fetch_start),
        .line_end    (line_end),
        .row_clr     (row_clr),
        .frame_tick  (frame_tick)
    );

    // row/sub describe the line currently being scanned
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            row <= '0;
            sub <= '0;
        end else if (row_clr) begin
            row <= '0;
            sub <= '0;
        end else if (line_end && disp_line) begin
            if (sub == SW'(ROW_LINES - 1)) begin
                sub <= '0;
                row <= row + 1'b1;
            end else begin
                sub <= sub + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state     <= FIDLE;
            address_a <= '0;
            linebuf   <= '0;
        end else begin
            unique case (state)
                FIDLE:  if (fetch_start) state <= FADDR;
                FADDR: begin
                    address_a <= row;
                    state     <= FWAIT;
                end
                FWAIT:  state <= FLATCH;
                FLATCH: state <= FIDLE;
                default: state <= FIDLE;
            endcase
            if (!disp_line) linebuf <= '0;
            else if (state == FLATCH) linebuf <= q_a;
        end
    end

    // Bit 63 is the leftmost pixel, hence the inverted index
    always_comb begin
        lvl = LVL_BLACK;
        if (in_sync) lvl = LVL_SYNC;
        else if (in_active && disp_line && linebuf[~pix]) lvl = LVL_WHITE;
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) {high, low} <= LVL_SYNC;
        else {high, low} <= lvl;
    end

endmodule

// File: tb/tb_ntsc_scanout.sv
// Directed bench for ntsc_scanout using a shrunken raster.
// A small registered VRAM model drives q_a.
module tb_ntsc_scanout;
    import ntsc_pkg::*;

    localparam int LC = 240;
    localparam int HS = 10;
    localparam int BP = 10;
    localparam int HO = 10;
    localparam int PC = 3;
    localparam int LN = 80;
    localparam int VS = 3;
    localparam int VST = 8;
    localparam int RL = 2;

    logic        clock;
    logic        aclr_n;
    logic [4:0]  address_a;
    logic [63:0] q_a;
    logic        clock_a;
    logic        high;
    logic        low;
    logic        frame_tick;

    logic [63:0] vram [32];
    int checks;
    int errors;
    int cyc;
    int first_tick;

    ntsc_scanout #(
        .LINE_CLKS   (LC),
        .HSYNC_CLKS  (HS),
        .BP_CLKS     (BP),
        .H_OFFSET    (HO),
        .PIX_CLKS    (PC),
        .LINES       (LN),
        .VSYNC_LINES (VS),
        .V_START     (VST),
        .ROW_LINES   (RL)
    ) dut (
        .clock      (clock),
        .aclr_n     (aclr_n),
        .address_a  (address_a),
        .q_a        (q_a),
        .clock_a    (clock_a),
        .high       (high),
        .low        (low),
        .frame_tick (frame_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock_a) q_a <= vram[address_a];

    always @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    always @(negedge clock) begin
        if (aclr_n && frame_tick && first_tick == 0) first_tick = cyc;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Stop on the negedge where the output shows counter position (l, c)
    task automatic wait_pos(input int l, input int c);
        int target;
        int g;
        target = l * LC + c + 1;
        g = 0;
        while (cyc < target && g < 200000) begin
            @(negedge clock);
            g++;
        end
        if (cyc != target) check("wait_pos", 64'(cyc), 64'(target));
    endtask

    task automatic lvl_at(input string tag, input int l, input int c,
                          input logic [1:0] exp);
        wait_pos(l, c);
        check(tag, {62'd0, high, low}, {62'd0, exp});
    endtask

    task automatic scan_white(input string tag, input int l0, input int l1);
        int whites;
        int n;
        whites = 0;
        n = (l1 - l0 + 1) * LC;
        wait_pos(l0, 0);
        for (int i = 0; i < n; i++) begin
            if ({high, low} == 2'b11 || {high, low} == 2'b10) whites++;
            if (i < n - 1) @(negedge clock);
        end
        check(tag, 64'(whites), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        first_tick = 0;
        aclr_n = 1'b0;
        for (int r = 0; r < 32; r++) vram[r] = '1;
        vram[10] = 64'h8000_0000_0000_0001;

        repeat (10) @(posedge clock);
        #1;
        check("rst_lvl", {62'd0, high, low}, 64'd0);
        check("rst_addr", 64'(address_a), 64'd0);
        check("rst_tick", 64'(frame_tick), 64'd0);

        @(negedge clock);
        aclr_n = 1'b1;

        lvl_at("vs_start", 1, 0, LVL_SYNC);
        lvl_at("vs_last", 1, 229, LVL_SYNC);
        lvl_at("vs_serr", 1, 230, LVL_BLACK);
        scan_white("top_blank", 3, 7);

        lvl_at("l8_pix0", 8, 30, LVL_WHITE);
        wait_pos(8, 100);
        vram[0] = '0;
        lvl_at("l8_keep", 8, 221, LVL_WHITE);
        lvl_at("l8_end", 8, 222, LVL_BLACK);
        lvl_at("l9_new", 9, 30, LVL_BLACK);
        lvl_at("l9_mid", 9, 100, LVL_BLACK);

        lvl_at("h_sync0", 28, 0, LVL_SYNC);
        lvl_at("h_sync9", 28, 9, LVL_SYNC);
        lvl_at("h_bp", 28, 10, LVL_BLACK);
        lvl_at("h_pre", 28, 29, LVL_BLACK);
        lvl_at("p0_a", 28, 30, LVL_WHITE);
        lvl_at("p0_b", 28, 32, LVL_WHITE);
        lvl_at("p1", 28, 33, LVL_BLACK);
        wait_pos(28, 100);
        check("addr_r10", 64'(address_a), 64'd10);
        check("p_mid", {62'd0, high, low}, {62'd0, LVL_BLACK});
        lvl_at("p62", 28, 218, LVL_BLACK);
        lvl_at("p63_a", 28, 219, LVL_WHITE);
        lvl_at("p63_b", 28, 221, LVL_WHITE);
        lvl_at("p_after", 28, 222, LVL_BLACK);
        lvl_at("rep_p0", 29, 30, LVL_WHITE);
        lvl_at("rep_p63", 29, 219, LVL_WHITE);
        check("rep_addr", 64'(address_a), 64'd10);

        lvl_at("last_row", 71, 221, LVL_WHITE);
        scan_white("bot_blank", 72, 79);
        @(negedge clock);
        check("tick_pos", 64'(first_tick), 64'(LN * LC));
        check("tick_width", 64'(frame_tick), 64'd0);

        wait_pos(LN + 20, 11);
        check("mf_state", 64'(dut.state), 64'(FWAIT));
        check("mf_addr", 64'(address_a), 64'd6);
        check("mf_pre", {62'd0, high, low}, {62'd0, LVL_BLACK});
        aclr_n = 1'b0;
        #1;
        check("mf_lvl", {62'd0, high, low}, 64'd0);
        check("mf_addr0", 64'(address_a), 64'd0);
        check("mf_lbuf", dut.linebuf, 64'd0);
        repeat (3) @(negedge clock);
        aclr_n = 1'b1;
        lvl_at("rs_sync", 0, 0, LVL_SYNC);
        wait_pos(0, 20);
        check("rs_lbuf", dut.linebuf, 64'd0);
        check("rs_state", 64'(dut.state), 64'(FIDLE));
        check("rs_tick", 64'(frame_tick), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
